instr_window: RTL

- Central entry buffer of the out-of-order core.
- The dispatch stage writes decoded instructions into it, the execute/writeback units mark them executed, and the commit stage retires them.
- It is the upstream producer of the per-entry state/tag array that the commit stage searches for executed entries with maximum tag.
- Tags encode age: tag 0 = unused; a larger tag means older; live tags are always distinct and lie in 1..BUF_SIZE.

---
 rtl/instr_window.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_window.sv
// Central instruction window of the out-of-order core: dispatch allocates
// entries, writeback marks them executed, commit retires them; tags encode age.
module instr_window #(
  parameter int BUF_SIZE     = 8,
  parameter int BUF_SIZE_LOG = 3,
  parameter int DATA_W       = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        disp_valid,
  input  logic [2*DATA_W-1:0]               disp_data,
  output logic                              disp_ready,
  output logic [2*BUF_SIZE_LOG-1:0]         disp_idx,
  input  logic [1:0]                        wb_valid,
  input  logic [2*BUF_SIZE_LOG-1:0]         wb_idx,
  input  logic [2*DATA_W-1:0]               wb_result,
  input  logic [1:0]                        cm_valid,
  input  logic [2*BUF_SIZE_LOG-1:0]         cm_idx,
  output logic [2*BUF_SIZE-1:0]             ent_state,
  output logic [(BUF_SIZE_LOG+1)*BUF_SIZE-1:0] ent_tag,
  output logic [DATA_W*BUF_SIZE-1:0]        ent_data,
  output logic [DATA_W*BUF_SIZE-1:0]        ent_result,
  output logic [BUF_SIZE_LOG:0]             free_count
);

  localparam int TW = BUF_SIZE_LOG + 1;
  localparam int BL = BUF_SIZE_LOG;

  typedef enum logic [1:0] {
    S_NOT_USED = 2'b00,
    S_WAITING  = 2'b01,
    S_EXECUTED = 2'b10
  } state_t;

  state_t              state_q  [BUF_SIZE];
  logic [TW-1:0]       tag_q    [BUF_SIZE];
  logic [DATA_W-1:0]   data_q   [BUF_SIZE];
  logic [DATA_W-1:0]   result_q [BUF_SIZE];
  logic [TW-1:0]       free_q;

  logic [BL-1:0]       alloc_idx0;
  logic [BL-1:0]       alloc_idx1;
  logic                found0;
  logic                found1;
  logic                accept;
  logic [1:0]          n_alloc;

  logic [BUF_SIZE-1:0] wb_hit;
  logic [BUF_SIZE-1:0] cm_hit;
  logic [DATA_W-1:0]   wb_val   [BUF_SIZE];
  logic [TW-1:0]       dec      [BUF_SIZE];
  logic [TW-1:0]       n_commit;

  assign disp_ready = (free_q >= TW'(2));
  assign accept     = disp_valid[0] && disp_ready;
  assign n_alloc    = accept ? (disp_valid[1] ? 2'd2 : 2'd1) : 2'd0;
  assign disp_idx   = {alloc_idx1, alloc_idx0};
  assign free_count = free_q;

  // Two lowest free entries, searched on current state only
  always_comb begin
    alloc_idx0 = '0;
    alloc_idx1 = '0;
    found0     = 1'b0;
    found1     = 1'b0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      if (state_q[i] == S_NOT_USED) begin
        if (!found0) begin
          alloc_idx0 = BL'(i);
          found0     = 1'b1;
        end else if (!found1) begin
          alloc_idx1 = BL'(i);
          found1     = 1'b1;
        end
      end
    end
  end

  // Commit sees pre-writeback state, so a same-cycle wb+commit is not freed
  always_comb begin
    n_commit = '0;
    for (int i = 0; i < BUF_SIZE; i++) begin
      wb_hit[i] = 1'b0;
      wb_val[i] = '0;
      cm_hit[i] = 1'b0;
      if (state_q[i] == S_WAITING) begin
        if (wb_valid[0] && wb_idx[0 +: BL] == BL'(i)) begin
          wb_hit[i] = 1'b1;
          wb_val[i] = wb_result[0 +: DATA_W];
        end else if (wb_valid[1] && wb_idx[BL +: BL] == BL'(i)) begin
          wb_hit[i] = 1'b1;
          wb_val[i] = wb_result[DATA_W +: DATA_W];
        end
      end
      if (state_q[i] == S_EXECUTED &&
          ((cm_valid[0] && cm_idx[0 +: BL] == BL'(i)) ||
           (cm_valid[1] && cm_idx[BL +: BL] == BL'(i)))) begin
        cm_hit[i] = 1'b1;
      end
      if (cm_hit[i]) n_commit = n_commit + TW'(1);
    end
  end

  // Each retired younger entry pulls every older survivor's tag down by one
  always_comb begin
    for (int i = 0; i < BUF_SIZE; i++) begin
      dec[i] = '0;
      for (int j = 0; j < BUF_SIZE; j++) begin
        if (cm_hit[j] && tag_q[j] < tag_q[i]) dec[i] = dec[i] + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        state_q[i]  <= S_NOT_USED;
        tag_q[i]    <= '0;
        data_q[i]   <= '0;
        result_q[i] <= '0;
      end
      free_q <= TW'(BUF_SIZE);
    end else begin
      for (int i = 0; i < BUF_SIZE; i++) begin
        if (cm_hit[i]) begin
          state_q[i]  <= S_NOT_USED;
          tag_q[i]    <= '0;
          result_q[i] <= '0;
        end else if (accept && alloc_idx0 == BL'(i)) begin
          state_q[i]  <= S_WAITING;
          tag_q[i]    <= TW'(n_alloc);
          data_q[i]   <= disp_data[0 +: DATA_W];
          result_q[i] <= '0;
        end else if (accept && disp_valid[1] && alloc_idx1 == BL'(i)) begin
          state_q[i]  <= S_WAITING;
          tag_q[i]    <= TW'(1);
          data_q[i]   <= disp_data[DATA_W +: DATA_W];
          result_q[i] <= '0;
        end else if (state_q[i] != S_NOT_USED) begin
          tag_q[i] <= tag_q[i] + TW'(n_alloc) - dec[i];
          if (wb_hit[i]) begin
            state_q[i]  <= S_EXECUTED;
            result_q[i] <= wb_val[i];
          end
        end
      end
      free_q <= free_q - TW'(n_alloc) + n_commit;
    end
  end

  for (genvar g = 0; g < BUF_SIZE; g++) begin : g_flatten
    assign ent_state[2*g +: 2]       = state_q[g];
    assign ent_tag[TW*g +: TW]       = tag_q[g];
    assign ent_data[DATA_W*g +: DATA_W]   = data_q[g];
    assign ent_result[DATA_W*g +: DATA_W] = result_q[g];
  end

endmodule
